// File: rtl/axis_tg_pkg.sv
// Shared definitions for the AXI-Stream traffic format: beat field layout,
// error flag bit positions and the checker framing states.
package axis_tg_pkg;

    // Beat field layout (LSB offset and width of each field)
    localparam int SEQ_LSB = 0;
    localparam int SEQ_W   = 16;
    localparam int SRC_LSB = 16;
    localparam int SRC_W   = 8;
    localparam int IDX_LSB = 24;
    localparam int IDX_W   = 8;
    localparam int LEN_LSB = 32;
    localparam int LEN_W   = 8;

    localparam int NUM_ERR = 5;

    // Bit positions inside err_flags
    typedef enum logic [2:0] {
        ERR_DEST = 3'd0,
        ERR_SRC  = 3'd1,
        ERR_SEQ  = 3'd2,
        ERR_IDX  = 3'd3,
        ERR_LEN  = 3'd4
    } err_bit_e;

    // Framing state: expecting a header beat, or inside a packet body
    typedef enum logic {
        HEAD = 1'b0,
        BODY = 1'b1
    } chk_state_e;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, used as a backpressure source.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;
    logic        fb;

    // Shift left, feeding back the XOR of the tap bits
    always_comb begin
        fb      = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];
        state_d = state_q;
        if (en) begin
            state_d = {state_q[14:0], fb};
        end
    end

    // State register, seeded on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/axis_traffic_checker.sv
// AXI-Stream sink that validates routing, framing and per-source sequence of
// every accepted beat, with random backpressure and sticky error reporting.
module axis_traffic_checker
    import axis_tg_pkg::*;
#(
    parameter int          TDATA_WIDTH = 512,
    parameter int          TDEST_WIDTH = 4,
    parameter int          MY_ADDR     = 0,
    parameter int          NUM_SOURCES = 4,
    parameter int          SEQ_WIDTH   = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   clk_usr,
    input  logic                   rst_n,
    input  logic                   axis_in_tvalid,
    output logic                   axis_in_tready,
    input  logic [TDATA_WIDTH-1:0] axis_in_tdata,
    input  logic                   axis_in_tlast,
    input  logic [TDEST_WIDTH-1:0] axis_in_tdest,
    input  logic                   stall_en,
    input  logic                   clr,
    output logic [31:0]            pkt_count,
    output logic [31:0]            beat_count,
    output logic [15:0]            err_count,
    output logic [NUM_ERR-1:0]     err_flags
);

    // Handshake: a beat transfers on a rising edge where tvalid and tready
    // are both high; tready is a flop and never looks at tvalid.

    localparam logic [SRC_W:0] NSRC = (SRC_W + 1)'(NUM_SOURCES);

    logic [15:0] lfsr_state;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk_usr),
        .rst_n (rst_n),
        .en    (1'b1),
        .state (lfsr_state)
    );

    chk_state_e           state_q, state_d;
    logic                 tready_q, tready_d;
    logic [SRC_W-1:0]     hdr_src_q, hdr_src_d;
    logic [SEQ_WIDTH-1:0] hdr_seq_q, hdr_seq_d;
    logic [LEN_W-1:0]     hdr_len_q, hdr_len_d;
    logic [IDX_W-1:0]     exp_idx_q, exp_idx_d;
    logic [SEQ_WIDTH-1:0] seq_tab_q [NUM_SOURCES];
    logic [SEQ_WIDTH-1:0] seq_tab_d [NUM_SOURCES];
    logic [31:0]          pkt_count_q, pkt_count_d;
    logic [31:0]          beat_count_q, beat_count_d;
    logic [15:0]          err_count_q, err_count_d;
    logic [NUM_ERR-1:0]   err_flags_q, err_flags_d;

    logic [15:0]          f_seq16;
    logic [SEQ_WIDTH-1:0] f_seq;
    logic [SRC_W-1:0]     f_src;
    logic [IDX_W-1:0]     f_idx;
    logic [LEN_W-1:0]     f_len;
    logic [SEQ_WIDTH-1:0] exp_seq;
    logic                 acc;
    logic                 src_bad;
    logic [NUM_ERR-1:0]   err_v;

    // Upper data bits and high LFSR bits are intentionally ignored
    logic unused_bits;
    assign unused_bits = ^{axis_in_tdata, lfsr_state};

    assign f_seq16 = axis_in_tdata[SEQ_LSB +: SEQ_W];
    assign f_seq   = f_seq16[SEQ_WIDTH-1:0];
    assign f_src   = axis_in_tdata[SRC_LSB +: SRC_W];
    assign f_idx   = axis_in_tdata[IDX_LSB +: IDX_W];
    assign f_len   = axis_in_tdata[LEN_LSB +: LEN_W];
    assign acc     = axis_in_tvalid & tready_q;
    assign src_bad = {1'b0, f_src} >= NSRC;

    // Look up the expected sequence number for the beat's source
    always_comb begin
        exp_seq = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (f_src == SRC_W'(i)) begin
                exp_seq = seq_tab_q[i];
            end
        end
    end

    // Per-beat checks against the framing state and latched header
    always_comb begin
        err_v           = '0;
        err_v[ERR_DEST] = axis_in_tdest != TDEST_WIDTH'(MY_ADDR);
        err_v[ERR_SRC]  = src_bad;
        if (state_q == HEAD) begin
            err_v[ERR_SEQ] = !src_bad && (f_seq != exp_seq);
            err_v[ERR_IDX] = f_idx != '0;
        end else begin
            err_v[ERR_SEQ] = !src_bad && ((f_seq != hdr_seq_q) ||
                             (f_src != hdr_src_q) || (f_len != hdr_len_q));
            err_v[ERR_IDX] = f_idx != exp_idx_q;
        end
        err_v[ERR_LEN] = (axis_in_tlast != (f_idx == (f_len - LEN_W'(1)))) ||
                         (f_len == '0);
    end

    // Next-state for framing FSM, seq table, counters and backpressure
    always_comb begin
        state_d      = state_q;
        hdr_src_d    = hdr_src_q;
        hdr_seq_d    = hdr_seq_q;
        hdr_len_d    = hdr_len_q;
        exp_idx_d    = exp_idx_q;
        seq_tab_d    = seq_tab_q;
        pkt_count_d  = pkt_count_q;
        beat_count_d = beat_count_q;
        err_count_d  = err_count_q;
        err_flags_d  = err_flags_q;
        tready_d     = ~stall_en | lfsr_state[0];

        if (acc) begin
            if (state_q == HEAD) begin
                // The table resynchronises to whatever arrived, so a single
                // lost packet produces a single SEQ error.
                for (int i = 0; i < NUM_SOURCES; i++) begin
                    if (!src_bad && (f_src == SRC_W'(i))) begin
                        seq_tab_d[i] = f_seq + SEQ_WIDTH'(1);
                    end
                end
                if (!axis_in_tlast) begin
                    hdr_src_d = f_src;
                    hdr_seq_d = f_seq;
                    hdr_len_d = f_len;
                    exp_idx_d = IDX_W'(1);
                    state_d   = BODY;
                end
            end else begin
                exp_idx_d = exp_idx_q + IDX_W'(1);
                if (axis_in_tlast) begin
                    state_d = HEAD;
                end
            end
            beat_count_d = beat_count_q + 32'd1;
            if (axis_in_tlast) begin
                pkt_count_d = pkt_count_q + 32'd1;
            end
            if ((|err_v) && (err_count_q != 16'hFFFF)) begin
                err_count_d = err_count_q + 16'd1;
            end
            err_flags_d = err_flags_q | err_v;
        end

        // Clear overrides counters, flags and framing but keeps the seq table
        if (clr) begin
            state_d      = HEAD;
            pkt_count_d  = '0;
            beat_count_d = '0;
            err_count_d  = '0;
            err_flags_d  = '0;
        end
    end

    // Register all checker state
    always_ff @(posedge clk_usr or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HEAD;
            tready_q     <= 1'b0;
            hdr_src_q    <= '0;
            hdr_seq_q    <= '0;
            hdr_len_q    <= '0;
            exp_idx_q    <= '0;
            for (int i = 0; i < NUM_SOURCES; i++) begin
                seq_tab_q[i] <= '0;
            end
            pkt_count_q  <= '0;
            beat_count_q <= '0;
            err_count_q  <= '0;
            err_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            tready_q     <= tready_d;
            hdr_src_q    <= hdr_src_d;
            hdr_seq_q    <= hdr_seq_d;
            hdr_len_q    <= hdr_len_d;
            exp_idx_q    <= exp_idx_d;
            seq_tab_q    <= seq_tab_d;
            pkt_count_q  <= pkt_count_d;
            beat_count_q <= beat_count_d;
            err_count_q  <= err_count_d;
            err_flags_q  <= err_flags_d;
        end
    end

    assign axis_in_tready = tready_q;
    assign pkt_count      = pkt_count_q;
    assign beat_count     = beat_count_q;
    assign err_count      = err_count_q;
    assign err_flags      = err_flags_q;

endmodule

// File: tb/tb_axis_traffic_checker.sv
// Self-checking bench for axis_traffic_checker: table of beats with
// hand-derived error masks, a counter scoreboard, and corner-case sequences.
module tb_axis_traffic_checker;

    localparam int TW  = 64;
    localparam int TDW = 4;

    logic           clk_usr;
    logic           rst_n;
    logic           axis_in_tvalid;
    logic           axis_in_tready;
    logic [TW-1:0]  axis_in_tdata;
    logic           axis_in_tlast;
    logic [TDW-1:0] axis_in_tdest;
    logic           stall_en;
    logic           clr;
    logic [31:0]    pkt_count;
    logic [31:0]    beat_count;
    logic [15:0]    err_count;
    logic [4:0]     err_flags;

    axis_traffic_checker #(
        .TDATA_WIDTH (TW),
        .TDEST_WIDTH (TDW),
        .MY_ADDR     (0),
        .NUM_SOURCES (4),
        .SEQ_WIDTH   (16),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk_usr        (clk_usr),
        .rst_n          (rst_n),
        .axis_in_tvalid (axis_in_tvalid),
        .axis_in_tready (axis_in_tready),
        .axis_in_tdata  (axis_in_tdata),
        .axis_in_tlast  (axis_in_tlast),
        .axis_in_tdest  (axis_in_tdest),
        .stall_en       (stall_en),
        .clr            (clr),
        .pkt_count      (pkt_count),
        .beat_count     (beat_count),
        .err_count      (err_count),
        .err_flags      (err_flags)
    );

    typedef struct {
        logic [7:0]  src;
        logic [15:0] seq;
        logic [7:0]  idx;
        logic [7:0]  len;
        logic        last;
        logic [3:0]  dest;
        logic        clr;
        logic [4:0]  mask;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          low_cnt = 0;
    int          nostall_waits = 0;
    logic [84:0] exp_q[$];
    logic [31:0] m_pkt;
    logic [31:0] m_beat;
    logic [15:0] m_err;
    logic [4:0]  m_flags;
    logic [15:0] next_seq[4];
    vec_t        vecs[28];

    // ---------------- clock / reset ----------------
    initial clk_usr = 1'b0;
    always #5 clk_usr = ~clk_usr;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [TW-1:0] mk_data(input logic [15:0] seq, input logic [7:0] src,
                                             input logic [7:0] idx, input logic [7:0] len);
        logic [TW-1:0] d;
        d = {$urandom, $urandom};
        d[15:0]  = seq;
        d[23:16] = src;
        d[31:24] = idx;
        d[39:32] = len;
        return d;
    endfunction

    task automatic model_zero();
        m_pkt   = '0;
        m_beat  = '0;
        m_err   = '0;
        m_flags = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] pkt, input logic [31:0] beat,
                       input logic [15:0] err, input logic [4:0] flags);
        checks++;
        if (pkt_count !== pkt) begin
            errors++;
            $display("FAIL %s pkt_count: got %0d expected %0d", name, pkt_count, pkt);
        end
        checks++;
        if (beat_count !== beat) begin
            errors++;
            $display("FAIL %s beat_count: got %0d expected %0d", name, beat_count, beat);
        end
        checks++;
        if (err_count !== err) begin
            errors++;
            $display("FAIL %s err_count: got %0d expected %0d", name, err_count, err);
        end
        checks++;
        if (err_flags !== flags) begin
            errors++;
            $display("FAIL %s err_flags: got %b expected %b", name, err_flags, flags);
        end
    endtask

    // ---------------- driver tasks (called at posedge+2) ----------------
    task automatic send(input vec_t v);
        logic rdy;
        logic accepted;
        int   waits;
        axis_in_tdata  = mk_data(v.seq, v.src, v.idx, v.len);
        axis_in_tdest  = v.dest;
        axis_in_tlast  = v.last;
        clr            = v.clr;
        axis_in_tvalid = 1'b1;
        accepted = 1'b0;
        waits    = 0;
        while (!accepted && waits < 200) begin
            rdy = axis_in_tready;
            @(posedge clk_usr);
            if (rdy) accepted = 1'b1;
            else begin
                waits++;
                #2;
            end
        end
        if (accepted) begin
            if (!stall_en) nostall_waits += waits;
            if (v.clr) model_zero();
            else begin
                m_beat = m_beat + 32'd1;
                if (v.last) m_pkt = m_pkt + 32'd1;
                if ((v.mask != 5'b0) && (m_err != 16'hFFFF)) m_err = m_err + 16'd1;
                m_flags = m_flags | v.mask;
            end
            exp_q.push_back({m_pkt, m_beat, m_err, m_flags});
            #2;
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: beat src=%0d seq=%0d idx=%0d not accepted in 200 cycles",
                     v.src, v.seq, v.idx);
        end
        axis_in_tvalid = 1'b0;
        axis_in_tlast  = 1'b0;
        clr            = 1'b0;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send(vecs[i]);
    endtask

    task automatic clr_pulse(input string name);
        clr = 1'b1;
        @(posedge clk_usr);
        #2;
        clr = 1'b0;
        model_zero();
        chk(name, 32'd0, 32'd0, 16'd0, 5'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #6;
        @(negedge clk_usr);
        rst_n = 1'b1;
        @(posedge clk_usr);
        #2;
        model_zero();
        for (int i = 0; i < 4; i++) next_seq[i] = '0;
    endtask

    task automatic send_clean(input logic [7:0] src, input logic [15:0] seq,
                              input logic [7:0] idx, input logic [7:0] len, input logic last);
        vec_t v;
        v = '{src, seq, idx, len, last, 4'h0, 1'b0, 5'b0};
        send(v);
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clk_usr) begin
        logic [84:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({pkt_count, beat_count, err_count, err_flags} !== e) begin
                errors++;
                $display("FAIL scoreboard: got pkt=%0d beat=%0d err=%0d flags=%b expected pkt=%0d beat=%0d err=%0d flags=%b",
                         pkt_count, beat_count, err_count, err_flags,
                         e[84:53], e[52:21], e[20:5], e[4:0]);
            end
        end
    end

    always @(negedge clk_usr) begin
        if (rst_n && stall_en && !axis_in_tready) low_cnt++;
    end

    // ---------------- test ----------------
    initial begin
        rst_n          = 1'b0;
        axis_in_tvalid = 1'b0;
        axis_in_tdata  = '0;
        axis_in_tlast  = 1'b0;
        axis_in_tdest  = '0;
        stall_en       = 1'b0;
        clr            = 1'b0;
        model_zero();
        for (int i = 0; i < 4; i++) next_seq[i] = '0;

        // Table: {src, seq, idx, len, last, dest, clr, expected error mask}
        for (int p = 0; p < 3; p++)
            for (int b = 0; b < 4; b++)
                vecs[p*4+b] = '{8'd2, 16'(p), 8'(b), 8'd4, (b == 3), 4'h0, 1'b0, 5'b00000};
        vecs[12] = '{8'd1, 16'd0, 8'd0, 8'd1, 1'b1, 4'h0, 1'b0, 5'b00000};
        vecs[13] = '{8'd1, 16'd2, 8'd0, 8'd1, 1'b1, 4'h0, 1'b0, 5'b00100};
        vecs[14] = '{8'd1, 16'd3, 8'd0, 8'd1, 1'b1, 4'h0, 1'b0, 5'b00000};
        vecs[15] = '{8'd0, 16'd0, 8'd0, 8'd1, 1'b1, 4'h3, 1'b0, 5'b00001};
        vecs[16] = '{8'd0, 16'd1, 8'd0, 8'd4, 1'b0, 4'h0, 1'b0, 5'b00000};
        vecs[17] = '{8'd0, 16'd1, 8'd1, 8'd4, 1'b0, 4'h0, 1'b0, 5'b00000};
        vecs[18] = '{8'd0, 16'd1, 8'd2, 8'd4, 1'b1, 4'h0, 1'b0, 5'b10000};
        vecs[19] = '{8'd0, 16'd2, 8'd0, 8'd2, 1'b0, 4'h0, 1'b0, 5'b00000};
        vecs[20] = '{8'd0, 16'd2, 8'd1, 8'd2, 1'b1, 4'h0, 1'b0, 5'b00000};
        vecs[21] = '{8'd7, 16'd0, 8'd0, 8'd1, 1'b1, 4'h0, 1'b0, 5'b00010};
        vecs[22] = '{8'd0, 16'd3, 8'd1, 8'd1, 1'b1, 4'h0, 1'b0, 5'b11000};
        vecs[23] = '{8'd0, 16'd4, 8'd0, 8'd2, 1'b0, 4'h0, 1'b0, 5'b00000};
        vecs[24] = '{8'd0, 16'd9, 8'd1, 8'd2, 1'b1, 4'h0, 1'b0, 5'b00100};
        vecs[25] = '{8'd0, 16'd5, 8'd0, 8'd0, 1'b1, 4'h0, 1'b0, 5'b10000};
        vecs[26] = '{8'd2, 16'd3, 8'd0, 8'd1, 1'b1, 4'h0, 1'b1, 5'b00000};
        vecs[27] = '{8'd2, 16'd4, 8'd0, 8'd1, 1'b1, 4'h0, 1'b0, 5'b00000};

        // Reset state
        #7;
        checks++;
        if (axis_in_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_tready: got %b expected 0", axis_in_tready);
        end
        chk("reset", 32'd0, 32'd0, 16'd0, 5'b0);
        @(negedge clk_usr);
        rst_n = 1'b1;
        @(posedge clk_usr);
        #2;
        checks++;
        if (axis_in_tready !== 1'b1) begin
            errors++;
            $display("FAIL tready_after_rst: got %b expected 1", axis_in_tready);
        end

        run_rows(0, 11);
        chk("src2_three_pkts", 32'd3, 32'd12, 16'd0, 5'b00000);
        run_rows(12, 14);
        chk("seq_gap", 32'd6, 32'd15, 16'd1, 5'b00100);
        clr_pulse("clr_a");
        run_rows(15, 15);
        chk("bad_dest", 32'd1, 32'd1, 16'd1, 5'b00001);
        clr_pulse("clr_b");
        run_rows(16, 20);
        chk("early_tlast", 32'd2, 32'd5, 16'd1, 5'b10000);
        run_rows(21, 25);
        chk("src_idx_body_len0", 32'd6, 32'd10, 16'd5, 5'b11110);
        run_rows(26, 26);
        chk("clr_with_beat", 32'd0, 32'd0, 16'd0, 5'b00000);
        run_rows(27, 27);
        chk("seq_kept_after_clr", 32'd1, 32'd1, 16'd0, 5'b00000);

        // Clear mid-packet returns framing to HEAD
        send_clean(8'd3, 16'd0, 8'd0, 8'd4, 1'b0);
        clr_pulse("clr_mid_pkt");
        send_clean(8'd3, 16'd1, 8'd0, 8'd1, 1'b1);
        chk("after_mid_clr", 32'd1, 32'd1, 16'd0, 5'b00000);

        // Reset mid-packet discards the partial packet and the seq table
        send_clean(8'd3, 16'd2, 8'd0, 8'd4, 1'b0);
        do_reset();
        send_clean(8'd3, 16'd0, 8'd0, 8'd1, 1'b1);
        chk("after_mid_reset", 32'd1, 32'd1, 16'd0, 5'b00000);

        // Random backpressure, 250 packets x 4 beats from random sources
        do_reset();
        stall_en = 1'b1;
        for (int p = 0; p < 250; p++) begin
            int s;
            s = $urandom_range(0, 3);
            for (int b = 0; b < 4; b++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk_usr);
                    #2;
                end
                send_clean(8'(s), next_seq[s], 8'(b), 8'd4, (b == 3));
            end
            next_seq[s] = next_seq[s] + 16'd1;
        end
        stall_en = 1'b0;
        chk("stall_1000", 32'd250, 32'd1000, 16'd0, 5'b00000);
        checks++;
        if (low_cnt == 0) begin
            errors++;
            $display("FAIL stall_tready_low: got %0d low cycles expected > 0", low_cnt);
        end
        checks++;
        if (nostall_waits != 0) begin
            errors++;
            $display("FAIL nostall_ready: got %0d wait cycles expected 0", nostall_waits);
        end
        repeat (3) @(posedge clk_usr);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_traffic_checker.md
# axis_traffic_checker

Synthesizable AXI-Stream sink that terminates one `axis_out` endpoint of `axis_mesh` and validates every received beat. It checks that routing is correct, that framing is correct, and that each source delivers packets in sequence. It applies pseudo-random backpressure, counts packets, beats and errors, and latches sticky error flags for hardware bring-up and regression benches. Beat format is the standard traffic format defined in `axis_tg_pkg`: seq in `[15:0]`, src in `[23:16]`, beat index in `[31:24]`, packet length in beats in `[39:32]`; upper bits are not checked.

## Interface
- `TDATA_WIDTH`, 512, beat width; must be ≥ 40.
- `TDEST_WIDTH`, 4, destination field width.
- `MY_ADDR`, 0, endpoint address this checker expects in `tdest`.
- `NUM_SOURCES`, 4, valid source IDs are 0..NUM_SOURCES-1 (≤ 256).
- `SEQ_WIDTH`, 16, sequence width (≤ 16).
- `LFSR_SEED`, 16'hACE1, backpressure LFSR reset value, must be non-zero.

Ports:
- `clk_usr`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `axis_in_tvalid`  in  1  stream valid.
- `axis_in_tready`  out  1  stream ready.
- `axis_in_tdata`  in  TDATA_WIDTH  beat data.
- `axis_in_tlast`  in  1  last beat of packet.
- `axis_in_tdest`  in  TDEST_WIDTH  destination.
- `stall_en`  in  1  enable random backpressure.
- `clr`  in  1  synchronous clear of counters, flags and FSM.
- `pkt_count`  out  32  packets accepted (tlast beats), wraps.
- `beat_count`  out  32  beats accepted, wraps.
- `err_count`  out  16  erroneous beats, saturates at 16'hFFFF.
- `err_flags`  out  5  sticky {LEN, IDX, SEQ, SRC, DEST}, bits 4..0.

## Operation
- A beat is accepted when `tvalid && tready` at the rising edge of `clk_usr`. `tready` never depends on `tvalid`.
- Backpressure:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - Registered `tready` = `~stall_en | lfsr[0]`.
- FSM states:
  - HEAD: the next beat is a header. On an accepted beat without tlast, latch src/seq/len, set expected index = 1, go to BODY. With tlast, stay in HEAD.
  - BODY: on an accepted beat, increment the expected index. On tlast, go to HEAD.
  - Framing always follows `tlast`.
- Per-beat checks; every failing check sets its flag:
  - DEST: `tdest != MY_ADDR`.
  - SRC: src ≥ NUM_SOURCES. When set, SEQ is not checked and the seq table is not touched.
  - SEQ:
    - HEAD: seq ≠ expected_seq[src].
    - BODY: seq, src or len differs from the latched header.
  - IDX: HEAD requires index 0; BODY requires index == expected index.
  - LEN: `tlast` ≠ (index == len-1), or len == 0.
- Sequence table:
  - NUM_SOURCES × SEQ_WIDTH registers, reset 0.
  - On a HEAD beat with valid src, the entry is written with received seq + 1, modulo 2^SEQ_WIDTH. This resynchronises after a SEQ error, so one lost packet gives exactly one error.
- `err_count` increments by 1 per accepted beat with any flag set.
- Simultaneous `clr` and accepted beat: `clr` wins for counters and flags, and the FSM returns to HEAD. The seq table is not cleared by `clr`.

## Timing
- Reset values:
  - `tready` = 0.
  - All counters and `err_flags` = 0.
  - FSM = HEAD, LFSR = LFSR_SEED, seq table = 0.
- First cycle after reset release: `tready` = 1 if `stall_en` = 0.
- Counters and flags are registered and visible 1 cycle after the accepting edge.
- Reset mid-packet: the partial packet is discarded, and the next accepted beat is treated as a header.

## Structure
- `axis_tg_pkg`, shared with the future traffic generator, holds:
  - field offsets and widths (SEQ_LSB=0, SRC_LSB=16, IDX_LSB=24, LEN_LSB=32);
  - the `err_bit_e` enum (DEST=0, SRC, SEQ, IDX, LEN);
  - the `chk_state_e` enum {HEAD, BODY}.
- One sub-module: `lfsr16` (seed parameter, enable input, 16-bit state output).

## Test plan
- Reset, `stall_en`=0, source 2 sends 3 packets of len 4 with seq 0,1,2 to MY_ADDR → `pkt_count`=3, `beat_count`=12, `err_flags`=0.
- Source 1 sends seq 0 then seq 2 → SEQ flag set, `err_count`=1. A following seq 3 packet raises no new error.
- Single beat with `tdest`=4'h3 (MY_ADDR=0) → `err_flags`=5'b00001, `err_count`=1.
- Header len=4 but `tlast` on beat index 2 → LEN flag set. The FSM returns to HEAD, and the next clean packet is accepted error-free.
- `stall_en`=1 with 1000 beats → `tready` low on some cycles, no beats lost, and counts match the beats sent.
- `clr` pulsed coincident with an accepted beat → counters and flags read 0 the next cycle. Seq continuity per source is preserved.
